note_lane_engine: RTL and testbench
===================================

# note_lane_engine

Parametrised note scroller and hit judge for the dance game. It holds up to DEPTH falling notes in each of LANES lanes and scrolls them toward a fixed target line on each scroll tick. It judges player presses per lane against the target, reports misses, and drives a registered pixel-query output that the VGA colour stage ORs into VGA_R. It sits between the arrow pattern source (spawn handshake), the debounced button block, and the VGA timing counters.

## Interface
- LANES, 4, number of lanes (arrow directions)
- DEPTH, 8, note slots per lane
- POS_W, 9, width of a note's vertical position
- SPAWN_Y, 435, position written into a newly spawned note
- TARGET_Y, 45, target line position
- MISS_Y, 15, head position at which an unhit note is dropped as a miss
- WIN_PERFECT / WIN_GREAT / WIN_GOOD, 10 / 20 / 30, judge windows on |pos−TARGET_Y|
- LANE_X0, 314, left x of lane 0; LANE_PITCH, 100; NOTE_W, 36; NOTE_H, 70
- vga_clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- scroll_tick  in  1  one-cycle pulse; advances every note by one line
- spawn_valid  in  1  spawn request
- spawn_lane  in  clog2(LANES)  lane of the request
- spawn_ready  out  1  combinational; high when the requested lane is not full
- pressed  in  LANES  synchronised, debounced button levels
- h_counter, v_counter  in  10 each  current pixel from the VGA timing block
- note_pixel  out  1  registered; a note covers the pixel queried in the previous cycle
- judge_valid  out  1  one-cycle pulse per judgement
- judge_lane  out  clog2(LANES)  lane of the judgement
- score  out  2  3 perfect, 2 great, 1 good, 0 bad or miss
- miss  out  1  qualifies judge_valid: the judgement is a miss
- lane_full  out  LANES  per-lane full flags

## Operation
- Each lane is a circular FIFO: head/tail pointers plus count 0..DEPTH. The head is always the oldest note, which also has the lowest position.
- Spawn: a transfer occurs when spawn_valid && spawn_ready. The lane tail is written with SPAWN_Y. A full lane stalls the request. No bypass: a pop in the same cycle does not raise spawn_ready.
- Scroll: on scroll_tick every valid entry decrements by 1. A note spawned in the same cycle keeps SPAWN_Y.
- Miss: on scroll_tick, if the head is valid and head_pos == MISS_Y, the head is popped and a miss event is raised for that lane.
- Press: a rising edge of pressed[l] (registered previous level) is evaluated against the pre-decrement head position, with d = |head_pos − TARGET_Y| at POS_W+1 bits, unsigned.
  - d < WIN_PERFECT → 3
  - d < WIN_GREAT → 2
  - d < WIN_GOOD → 1
  - In all three cases the head is popped.
  - d ≥ WIN_GOOD → score 0, miss=0, no pop.
  - Empty lane → no event.
- Same-cycle miss pop and press edge on one lane: the miss wins and the press is dropped.
- Each lane has one pending-event register {valid, score, miss}.
  - An event arriving while the lane's register is valid is dropped; any pop still happens.
- Arbiter: each cycle the lowest-index lane with a pending event drives judge_valid/judge_lane/score/miss and clears its register.
- Rendering: note_pixel <= OR over all valid entries (l, pos) of the condition
  - h ∈ [LANE_X0+l·LANE_PITCH, LANE_X0+l·LANE_PITCH+NOTE_W), and
  - v ∈ [pos, pos+NOTE_H).
  - Compares are unsigned at 11 bits.

## Timing
- Reset (asynchronous, any time, including mid-operation) clears:
  - all FIFOs to empty, pending registers, press-edge history;
  - note_pixel=0, judge_valid=0, judge_lane=0, score=0, miss=0, lane_full=0;
  - spawn_ready therefore goes to 1.
- Press edge sampled in cycle N → pending set at the end of N → judge_valid in N+1 at the earliest.
  - With k lanes pending, the lane of arbitration rank k appears in N+k.
- Miss on scroll_tick in cycle N → judge_valid with miss=1 in N+1 at the earliest.
- Spawn accepted in cycle N → the entry is visible to the judge and renderer in N+1. lane_full updates in N+1.
- note_pixel latency is exactly 1 cycle from h_counter/v_counter.
- Position never wraps: entries are removed at MISS_Y before reaching 0.

## Test plan
- Spawn lane 2, then 390 scroll_ticks (pos=45), rising edge on pressed[2] → next cycle judge_valid=1, judge_lane=2, score=3, miss=0. Lane 2 is empty afterwards.
- 8 spawns to lane 0 → lane_full[0]=1, and spawn_ready=0 for spawn_lane=0 while spawn_ready=1 for lane 1. After a perfect hit in lane 0, lane_full[0]=0.
- Spawn lane 1, then 420 ticks → on the tick where pos==15: judge_valid=1, judge_lane=1, miss=1, score=0. Lane 1 is empty.
- Notes in lanes 0 and 3 both at pos 50, pressed[0] and pressed[3] rising in the same cycle N → N+1: lane 0 score 3; N+2: lane 3 score 3.
- Note at pos 100 in lane 0, press → judge score=0, miss=0, note still present at pos 100 (no tick).
- Note lane 1 at pos 200, query h=414,v=200 → note_pixel=1 next cycle. Query h=450,v=200 → 0. Query h=414,v=270 → 0. Assert reset mid-frame → note_pixel=0 and all lanes empty.

Source files
------------

// File: rtl/note_lane_engine_if.sv
// Spawn handshake from the arrow pattern source and the judgement stream toward scoring.
interface note_lane_engine_if #(
  parameter int LANES = 4
) ();
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic              spawn_valid;
  logic [LANE_W-1:0] spawn_lane;
  logic              spawn_ready;
  logic              judge_valid;
  logic [LANE_W-1:0] judge_lane;
  logic [1:0]        score;
  logic              miss;

  modport master (
    output spawn_valid, spawn_lane,
    input  spawn_ready, judge_valid, judge_lane, score, miss
  );

  modport slave (
    input  spawn_valid, spawn_lane,
    output spawn_ready, judge_valid, judge_lane, score, miss
  );
endinterface

// File: rtl/note_lane_engine.sv
// Per-lane circular FIFOs of falling notes: scrolling, miss drop, press judging and pixel query.
// DEPTH must be a power of two so the head/tail pointers wrap naturally.
module note_lane_engine #(
  parameter int LANES       = 4,
  parameter int DEPTH       = 8,
  parameter int POS_W       = 9,
  parameter int SPAWN_Y     = 435,
  parameter int TARGET_Y    = 45,
  parameter int MISS_Y      = 15,
  parameter int WIN_PERFECT = 10,
  parameter int WIN_GREAT   = 20,
  parameter int WIN_GOOD    = 30,
  parameter int LANE_X0     = 314,
  parameter int LANE_PITCH  = 100,
  parameter int NOTE_W      = 36,
  parameter int NOTE_H      = 70
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              scroll_tick,
  note_lane_engine_if.slave bus,
  input  logic [LANES-1:0]  pressed,
  input  logic [9:0]        h_counter,
  input  logic [9:0]        v_counter,
  output logic              note_pixel,
  output logic [LANES-1:0]  lane_full
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [POS_W-1:0] SPAWN_C = POS_W'(SPAWN_Y);
  localparam logic [POS_W-1:0] TGT_C   = POS_W'(TARGET_Y);
  localparam logic [POS_W-1:0] MISS_C  = POS_W'(MISS_Y);
  localparam logic [POS_W:0]   WIN_P_C = (POS_W+1)'(WIN_PERFECT);
  localparam logic [POS_W:0]   WIN_G_C = (POS_W+1)'(WIN_GREAT);
  localparam logic [POS_W:0]   WIN_D_C = (POS_W+1)'(WIN_GOOD);

  logic [POS_W-1:0] pos_q [LANES][DEPTH];
  logic [PTR_W-1:0] head_q [LANES];
  logic [PTR_W-1:0] tail_q [LANES];
  logic [CNT_W-1:0] cnt_q [LANES];
  logic [LANES-1:0] pressed_prev_q;
  logic [LANES-1:0] pend_vld_q;
  logic [LANES-1:0] pend_miss_q;
  logic [1:0]       pend_score_q [LANES];

  logic [DEPTH-1:0] ent_vld [LANES];
  logic [POS_W-1:0] head_pos [LANES];
  logic [1:0]       ev_score [LANES];
  logic [LANES-1:0] push, pop, ev_vld, ev_miss, grant;
  logic [PTR_W-1:0] ofs;
  logic             found;
  logic [10:0]      h11, v11, x_lo, y_lo;
  logic             pix_hit_p0;

  function automatic logic [POS_W:0] abs_dist(input logic [POS_W-1:0] p);
    logic signed [POS_W:0] diff;
    diff = $signed({1'b0, p}) - $signed({1'b0, TGT_C});
    return diff[POS_W] ? $unsigned(-diff) : $unsigned(diff);
  endfunction

  function automatic logic [1:0] grade(input logic [POS_W:0] d);
    logic [1:0] s;
    if (d < WIN_P_C)      s = 2'd3;
    else if (d < WIN_G_C) s = 2'd2;
    else if (d < WIN_D_C) s = 2'd1;
    else                  s = 2'd0;
    return s;
  endfunction

  assign bus.spawn_ready = (cnt_q[bus.spawn_lane] != FULL_C);
  assign h11 = {1'b0, h_counter};
  assign v11 = {1'b0, v_counter};

  // A miss on the head takes precedence over a press edge in the same cycle.
  always_comb begin
    push      = '0;
    pop       = '0;
    ev_vld    = '0;
    ev_miss   = '0;
    lane_full = '0;
    ofs       = '0;
    for (int l = 0; l < LANES; l++) begin
      ent_vld[l] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        ofs           = PTR_W'(i) - head_q[l];
        ent_vld[l][i] = (CNT_W'(ofs) < cnt_q[l]);
      end
      head_pos[l]  = pos_q[l][head_q[l]];
      ev_score[l]  = grade(abs_dist(head_pos[l]));
      ev_miss[l]   = scroll_tick && (cnt_q[l] != '0) && (head_pos[l] == MISS_C);
      ev_vld[l]    = ev_miss[l] || (pressed[l] && !pressed_prev_q[l] && (cnt_q[l] != '0));
      pop[l]       = ev_miss[l] || (ev_vld[l] && (ev_score[l] != 2'd0));
      push[l]      = bus.spawn_valid && (bus.spawn_lane == LANE_W'(l)) && (cnt_q[l] != FULL_C);
      lane_full[l] = (cnt_q[l] == FULL_C);
    end
  end

  always_comb begin
    grant           = '0;
    found           = 1'b0;
    bus.judge_lane  = '0;
    bus.score       = 2'd0;
    bus.miss        = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (pend_vld_q[l] && !found) begin
        found          = 1'b1;
        grant[l]       = 1'b1;
        bus.judge_lane = LANE_W'(l);
        bus.score      = pend_score_q[l];
        bus.miss       = pend_miss_q[l];
      end
    end
    bus.judge_valid = found;
  end

  always_comb begin
    pix_hit_p0 = 1'b0;
    x_lo       = '0;
    y_lo       = '0;
    for (int l = 0; l < LANES; l++) begin
      x_lo = 11'(LANE_X0 + l * LANE_PITCH);
      for (int i = 0; i < DEPTH; i++) begin
        y_lo = 11'(pos_q[l][i]);
        if (ent_vld[l][i] && (h11 >= x_lo) && (h11 < x_lo + 11'(NOTE_W)) &&
            (v11 >= y_lo) && (v11 < y_lo + 11'(NOTE_H)))
          pix_hit_p0 = 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        head_q[l]       <= '0;
        tail_q[l]       <= '0;
        cnt_q[l]        <= '0;
        pend_score_q[l] <= 2'd0;
      end
      pressed_prev_q <= '0;
      pend_vld_q     <= '0;
      pend_miss_q    <= '0;
      note_pixel     <= 1'b0;
    end else begin
      pressed_prev_q <= pressed;
      // p0 -> registered pixel output
      note_pixel     <= pix_hit_p0;
      for (int l = 0; l < LANES; l++) begin
        if (pop[l])  head_q[l] <= head_q[l] + 1'b1;
        if (push[l]) tail_q[l] <= tail_q[l] + 1'b1;
        cnt_q[l] <= cnt_q[l] + CNT_W'(push[l]) - CNT_W'(pop[l]);
        // An occupied pending slot drops new events, even in the cycle it is granted.
        if (pend_vld_q[l]) begin
          if (grant[l]) pend_vld_q[l] <= 1'b0;
        end else if (ev_vld[l]) begin
          pend_vld_q[l]   <= 1'b1;
          pend_miss_q[l]  <= ev_miss[l];
          pend_score_q[l] <= ev_miss[l] ? 2'd0 : ev_score[l];
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push[l] && (tail_q[l] == PTR_W'(i)))
          pos_q[l][i] <= SPAWN_C;
        else if (scroll_tick && ent_vld[l][i])
          pos_q[l][i] <= pos_q[l][i] - POS_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_note_lane_engine.sv
// Bench for note_lane_engine: directed sequences, a pixel-query table and a randomized run vs a queue model.
module tb_note_lane_engine;
  localparam int LANES = 4;
  localparam int DEPTH = 8;

  logic             vga_clk;
  logic             reset;
  logic             scroll_tick;
  logic [LANES-1:0] pressed;
  logic [9:0]       h_counter;
  logic [9:0]       v_counter;
  logic             note_pixel;
  logic [LANES-1:0] lane_full;

  note_lane_engine_if #(.LANES(LANES)) bus ();

  note_lane_engine #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .scroll_tick (scroll_tick),
    .bus         (bus),
    .pressed     (pressed),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .note_pixel  (note_pixel),
    .lane_full   (lane_full)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Reference model: each lane is a queue of note positions, oldest first.
  int       mq [LANES][$];
  bit       m_pv [LANES];
  int       m_ps [LANES];
  bit       m_pm [LANES];
  bit [3:0] m_prev;
  bit       m_pix;

  int checks;
  int failures;

  logic       s_jv, s_miss, s_rdy, s_pix;
  logic [1:0] s_jl, s_sc;
  logic [3:0] s_full;

  typedef struct {
    int h;
    int v;
    int exp_pix;
  } pix_vec_t;
  pix_vec_t pv [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      mq[l].delete();
      m_pv[l] = 1'b0;
      m_ps[l] = 0;
      m_pm[l] = 1'b0;
    end
    m_prev = '0;
    m_pix  = 1'b0;
  endtask

  task automatic model_cycle();
    int  g;
    int  d;
    int  sc;
    int  x0;
    int  lane_req;
    bit  mev;
    bit  pev;
    bit  pix;
    bit  push_ok;
    g = -1;
    for (int l = 0; l < LANES; l++) if (g < 0 && m_pv[l]) g = l;
    lane_req = int'(bus.spawn_lane);
    chk("judge_valid", int'(s_jv), (g >= 0) ? 1 : 0);
    if (g >= 0) begin
      chk("judge_lane", int'(s_jl), g);
      chk("judge_score", int'(s_sc), m_ps[g]);
      chk("judge_miss", int'(s_miss), int'(m_pm[g]));
    end
    chk("spawn_ready", int'(s_rdy), (mq[lane_req].size() < DEPTH) ? 1 : 0);
    for (int l = 0; l < LANES; l++)
      chk("lane_full", int'(s_full[l]), (mq[l].size() == DEPTH) ? 1 : 0);
    chk("note_pixel", int'(s_pix), int'(m_pix));

    push_ok = bus.spawn_valid && (mq[lane_req].size() < DEPTH);
    pix = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      x0 = 314 + 100 * l;
      foreach (mq[l][i])
        if (int'(h_counter) >= x0 && int'(h_counter) < x0 + 36 &&
            int'(v_counter) >= mq[l][i] && int'(v_counter) < mq[l][i] + 70)
          pix = 1'b1;
    end
    for (int l = 0; l < LANES; l++) begin
      mev = scroll_tick && mq[l].size() > 0 && mq[l][0] == 15;
      pev = pressed[l] && !m_prev[l] && mq[l].size() > 0 && !mev;
      sc = 0;
      if (pev) begin
        d = mq[l][0] - 45;
        if (d < 0) d = -d;
        sc = (d < 10) ? 3 : (d < 20) ? 2 : (d < 30) ? 1 : 0;
      end
      if (m_pv[l]) begin
        if (g == l) m_pv[l] = 1'b0;
      end else if (mev || pev) begin
        m_pv[l] = 1'b1;
        m_ps[l] = sc;
        m_pm[l] = mev;
      end
      if (mev || (pev && sc > 0)) void'(mq[l].pop_front());
      if (scroll_tick) foreach (mq[l][i]) mq[l][i] = mq[l][i] - 1;
      if (push_ok && lane_req == l) mq[l].push_back(435);
    end
    m_prev = pressed;
    m_pix  = pix;
  endtask

  task automatic step();
    @(negedge vga_clk);
    s_jv   = bus.judge_valid;
    s_jl   = bus.judge_lane;
    s_sc   = bus.score;
    s_miss = bus.miss;
    s_rdy  = bus.spawn_ready;
    s_full = lane_full;
    s_pix  = note_pixel;
    model_cycle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_note_pixel", int'(note_pixel), 0);
    chk("rst_judge_valid", int'(bus.judge_valid), 0);
    chk("rst_judge_lane", int'(bus.judge_lane), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_miss", int'(bus.miss), 0);
    chk("rst_lane_full", int'(lane_full), 0);
    chk("rst_spawn_ready", int'(bus.spawn_ready), 1);
    model_reset();
    @(posedge vga_clk);
    #1 reset = 1'b0;
  endtask

  task automatic spawn(input int lane);
    bus.spawn_valid = 1'b1;
    bus.spawn_lane  = 2'(lane);
    step();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    scroll_tick = 1'b1;
    repeat (n) step();
    scroll_tick = 1'b0;
  endtask

  task automatic query(input int h, input int v);
    h_counter = 10'(h);
    v_counter = 10'(v);
    step();
    step();
  endtask

  task automatic chk_judge(input string name, input int lane, input int score, input int miss);
    chk({name, "_valid"}, int'(s_jv), 1);
    chk({name, "_lane"}, int'(s_jl), lane);
    chk({name, "_score"}, int'(s_sc), score);
    chk({name, "_miss"}, int'(s_miss), miss);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    scroll_tick     = 1'b0;
    pressed         = '0;
    h_counter       = '0;
    v_counter       = '0;
    bus.spawn_valid = 1'b0;
    bus.spawn_lane  = '0;
    model_reset();

    pv[0] = '{414, 200, 1};
    pv[1] = '{450, 200, 0};
    pv[2] = '{414, 270, 0};
    pv[3] = '{449, 269, 1};
    pv[4] = '{413, 230, 0};
    pv[5] = '{430, 199, 0};
    pv[6] = '{449, 200, 1};
    pv[7] = '{314, 200, 0};
    pv[8] = '{514, 200, 0};
    pv[9] = '{430, 250, 1};

    @(posedge vga_clk);
    #1;
    apply_reset();

    // Perfect hit in lane 2 at the target line.
    spawn(2);
    ticks(390);
    pressed = 4'b0100;
    step();
    pressed = 4'b0000;
    step();
    chk_judge("perfect2", 2, 3, 0);
    query(514, 45);
    chk("lane2_empty_pix", int'(s_pix), 0);

    // Fill lane 0, check stall and per-lane ready, then free a slot with a hit.
    apply_reset();
    for (int k = 0; k < DEPTH; k++) spawn(0);
    bus.spawn_lane = 2'd0;
    step();
    chk("full0_flag", int'(s_full[0]), 1);
    chk("full0_ready", int'(s_rdy), 0);
    bus.spawn_lane = 2'd1;
    step();
    chk("lane1_ready", int'(s_rdy), 1);
    spawn(0);
    ticks(390);
    pressed = 4'b0001;
    step();
    pressed = 4'b0000;
    step();
    chk_judge("perfect0", 0, 3, 0);
    chk("full0_cleared", int'(s_full[0]), 0);

    // Unhit note in lane 1 scrolls to the miss line.
    apply_reset();
    spawn(1);
    ticks(421);
    step();
    chk_judge("miss1", 1, 0, 1);
    query(414, 20);
    chk("lane1_empty_pix", int'(s_pix), 0);

    // Simultaneous presses in lanes 0 and 3 are serialised by lane index.
    apply_reset();
    spawn(0);
    spawn(3);
    ticks(385);
    pressed = 4'b1001;
    step();
    step();
    chk_judge("dual_first", 0, 3, 0);
    step();
    chk_judge("dual_second", 3, 3, 0);
    pressed = 4'b0000;
    step();

    // Press far from the target: score 0, note stays in place.
    apply_reset();
    spawn(0);
    ticks(335);
    pressed = 4'b0001;
    step();
    pressed = 4'b0000;
    step();
    chk_judge("bad0", 0, 0, 0);
    query(314, 100);
    chk("bad0_still_top", int'(s_pix), 1);
    query(314, 99);
    chk("bad0_above", int'(s_pix), 0);

    // Pixel-query table against a lane 1 note at 200.
    apply_reset();
    spawn(1);
    ticks(235);
    for (int k = 0; k < 10; k++) begin
      query(pv[k].h, pv[k].v);
      chk($sformatf("pix_tbl%0d", k), int'(s_pix), pv[k].exp_pix);
    end
    h_counter = 10'd414;
    v_counter = 10'd200;
    step();
    apply_reset();
    query(414, 200);
    chk("pix_after_reset", int'(s_pix), 0);

    // Randomized traffic against the model, with one reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      bus.spawn_valid = ($urandom_range(0, 5) == 0);
      bus.spawn_lane  = 2'($urandom_range(0, 3));
      scroll_tick     = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) pressed = 4'($urandom);
      h_counter = 10'($urandom_range(300, 720));
      v_counter = 10'($urandom_range(0, 520));
      step();
      if (c == 2500) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
